// File: rtl/div_pipe_param.sv
// div_pipe_param: fully pipelined signed/unsigned restoring divider with valid/ready, flush and tag passthrough.
module div_pipe_param #(
  parameter int WIDTH = 32,
  parameter int BITS_PER_STAGE = 4,
  parameter int TAG_W = 5
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_signed,
  input  logic [WIDTH-1:0] in_dividend,
  input  logic [WIDTH-1:0] in_divisor,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_quot,
  output logic [WIDTH-1:0] out_rem,
  output logic             out_dbz,
  output logic             out_ovf,
  output logic [TAG_W-1:0] out_tag,
  output logic             busy
);
  localparam int S = WIDTH / BITS_PER_STAGE;
  localparam int W = WIDTH;
  logic             adv, sa, sb, ovf_d;
  logic [S:0]       v_q, negq_q, negr_q, dbz_q, ovf_q;
  logic [W:0]       r_q [S+1];
  logic [W:0]       r_d [S+1];
  logic [W-1:0]     n_q [S+1];
  logic [W-1:0]     n_d [S+1];
  logic [W-1:0]     d_q [S];
  logic [TAG_W-1:0] tag_q [S+1];
  logic             out_valid_q, out_dbz_q, out_ovf_q;
  logic [W-1:0]     out_quot_q, out_rem_q;
  logic [TAG_W-1:0] out_tag_q;
  assign adv       = ~out_valid_q | out_ready;
  assign in_ready  = adv & ~flush;
  assign busy      = |v_q | out_valid_q;
  assign sa        = in_signed & in_dividend[W-1];
  assign sb        = in_signed & in_divisor[W-1];
  assign ovf_d     = in_signed & (in_dividend == {1'b1, {(W-1){1'b0}}}) & (&in_divisor);
  assign out_valid = out_valid_q;
  assign out_quot  = out_quot_q;
  assign out_rem   = out_rem_q;
  assign out_dbz   = out_dbz_q;
  assign out_ovf   = out_ovf_q;
  assign out_tag   = out_tag_q;
  // n holds the not-yet-consumed dividend bits, shifting out MSB-first while quotient bits shift in.
  always_comb begin
    r_d[0] = '0;
    n_d[0] = sa ? -in_dividend : in_dividend;
    for (int k = 1; k <= S; k++) begin
      r_d[k] = r_q[k-1];
      n_d[k] = n_q[k-1];
      for (int b = 0; b < BITS_PER_STAGE; b++) begin
        r_d[k] = {r_d[k][W-1:0], n_d[k][W-1]};
        n_d[k] = {n_d[k][W-2:0], r_d[k] >= {1'b0, d_q[k-1]}};
        r_d[k] = n_d[k][0] ? r_d[k] - {1'b0, d_q[k-1]} : r_d[k];
      end
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      v_q         <= '0;
      negq_q      <= '0;
      negr_q      <= '0;
      dbz_q       <= '0;
      ovf_q       <= '0;
      out_valid_q <= 1'b0;
      out_quot_q  <= '0;
      out_rem_q   <= '0;
      out_dbz_q   <= 1'b0;
      out_ovf_q   <= 1'b0;
      out_tag_q   <= '0;
      for (int k = 0; k <= S; k++) begin
        r_q[k]   <= '0;
        n_q[k]   <= '0;
        tag_q[k] <= '0;
      end
      for (int k = 0; k < S; k++) d_q[k] <= '0;
    end else begin
      if (flush) begin
        v_q         <= '0;
        out_valid_q <= 1'b0;
      end else if (adv) begin
        v_q         <= {v_q[S-1:0], in_valid};
        out_valid_q <= v_q[S];
      end
      if (adv) begin
        negq_q   <= {negq_q[S-1:0], sa ^ sb};
        negr_q   <= {negr_q[S-1:0], sa};
        dbz_q    <= {dbz_q[S-1:0], in_divisor == '0};
        ovf_q    <= {ovf_q[S-1:0], ovf_d};
        tag_q[0] <= in_tag;
        d_q[0]   <= sb ? -in_divisor : in_divisor;
        for (int k = 0; k <= S; k++) begin
          r_q[k] <= r_d[k];
          n_q[k] <= n_d[k];
        end
        for (int k = 1; k <= S; k++) tag_q[k] <= tag_q[k-1];
        for (int k = 1; k < S; k++) d_q[k] <= d_q[k-1];
        out_quot_q <= dbz_q[S] ? '1 : negq_q[S] ? -n_q[S] : n_q[S];
        out_rem_q  <= negr_q[S] ? -r_q[S][W-1:0] : r_q[S][W-1:0];
        out_dbz_q  <= dbz_q[S];
        out_ovf_q  <= ovf_q[S];
        out_tag_q  <= tag_q[S];
      end
    end
  end
endmodule
